// File: rtl/regfile_read_arbiter_if.sv
// Bundle between the shared register-file read mux, its requesters and the response consumer.
// The arbiter takes the slave side; the environment (requesters, mux, consumer) takes the master side.
interface regfile_read_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        grant;
  logic [ADDR_W-1:0]         mux_sel;
  logic [DATA_W-1:0]         mux_data;
  logic                      rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic [ID_W-1:0]           rd_id;
  logic                      rd_stall;

  modport master (
    output req, req_addr, mux_data, rd_stall,
    input  grant, mux_sel, rd_valid, rd_data, rd_id
  );

  modport slave (
    input  req, req_addr, mux_data, rd_stall,
    output grant, mux_sel, rd_valid, rd_data, rd_id
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of the register-file read mux with a one-deep registered
// response stage; a stalled, valid response freezes arbitration and the mux select.
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input logic                 clock,
  input logic                 reset,
  regfile_read_arbiter_if.slave bus
);

  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;
  logic [ID_W-1:0]   rd_id_q,    rd_id_d;
  logic [ID_W-1:0]   ptr_q,      ptr_d;
  logic [ADDR_W-1:0] sel_q,      sel_d;

  logic              blocked;
  logic              found;
  logic              gnt_vld;
  logic [ID_W-1:0]   win;
  logic [ADDR_W-1:0] win_addr;
  logic [NUM_REQ-1:0] grant_w;

  assign blocked = rd_valid_q & bus.rd_stall;

  // Search starts just after the last winner so every requester is served within NUM_REQ grants.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  assign gnt_vld  = found & ~blocked & ~reset;
  assign win_addr = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];

  always_comb begin
    grant_w = '0;
    if (gnt_vld) grant_w[win] = 1'b1;
  end

  assign bus.grant   = grant_w;
  // Without a grant the select holds so the mux output stays quiet and stable.
  assign bus.mux_sel = reset ? '0 : (gnt_vld ? win_addr : sel_q);

  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_id_d    = rd_id_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    if (gnt_vld) begin
      rd_data_d  = (win_addr == '0) ? '0 : bus.mux_data;
      rd_id_d    = win;
      rd_valid_d = 1'b1;
      ptr_d      = win;
      sel_d      = win_addr;
    end else if (!blocked) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      sel_q      <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_id_q    <= rd_id_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_id    = rd_id_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: inputs change on the falling edge, the
// combinational grant is checked before the rising edge, the response just after it.
module tb_regfile_read_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dead  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  regfile_read_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_read_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Register k of the file holds k*16+1; 'dead' forces a recognisable pattern onto the mux.
  assign bus.mux_data = dead ? 32'hDEADBEEF : {23'd0, bus.mux_sel, 4'h1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  // Apply req on the falling edge, check grant/mux_sel, then check the response after the rising edge.
  task automatic step(input string tag, input logic [3:0] rq,
                      input logic [3:0] exp_gnt, input logic [4:0] exp_sel,
                      input logic exp_vld, input logic [31:0] exp_data, input logic [1:0] exp_id);
    @(negedge clock);
    bus.req = rq;
    #1;
    check({tag, ".grant"},   32'(bus.grant),   32'(exp_gnt));
    check({tag, ".mux_sel"}, 32'(bus.mux_sel), 32'(exp_sel));
    @(posedge clock);
    #1;
    check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(exp_vld));
    if (exp_vld) begin
      check({tag, ".rd_data"}, bus.rd_data,      exp_data);
      check({tag, ".rd_id"},   32'(bus.rd_id),   32'(exp_id));
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.req = 4'b0000;
    bus.rd_stall = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [3:0]  rr_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [4:0]  rr_sel  [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1};
  logic [31:0] rr_data [5] = '{32'h11, 32'h21, 32'h31, 32'h41, 32'h11};
  logic [1:0]  rr_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    bus.req      = 4'b0001;
    bus.req_addr = '0;
    bus.rd_stall = 1'b0;
    set_addr(0, 5'd5);

    // Reset state: requests ignored, select forced low, response cleared
    repeat (2) @(posedge clock);
    #1;
    check("rst.grant",    32'(bus.grant),    32'h0);
    check("rst.mux_sel",  32'(bus.mux_sel),  32'h0);
    check("rst.rd_valid", 32'(bus.rd_valid), 32'h0);
    check("rst.rd_data",  bus.rd_data,       32'h0);
    check("rst.rd_id",    32'(bus.rd_id),    32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("first.grant",   32'(bus.grant),   32'h1);
    check("first.mux_sel", 32'(bus.mux_sel), 32'h5);
    @(posedge clock);
    #1;
    check("first.rd_valid", 32'(bus.rd_valid), 32'h1);
    check("first.rd_data",  bus.rd_data,       32'h51);
    check("first.rd_id",    32'(bus.rd_id),    32'h0);

    // Full round-robin sweep from a fresh pointer
    do_reset();
    for (int i = 0; i < 4; i++) set_addr(i, 5'(i + 1));
    for (int i = 0; i < 5; i++)
      step($sformatf("rr%0d", i), 4'b1111, rr_gnt[i], rr_sel[i], 1'b1, rr_data[i], rr_id[i]);

    // Register 0 reads zero whatever the mux returns; other registers pass the mux through
    dead = 1'b1;
    set_addr(0, 5'd0);
    step("zero", 4'b0001, 4'b0001, 5'd0, 1'b1, 32'h0, 2'd0);
    set_addr(0, 5'd7);
    step("dead", 4'b0001, 4'b0001, 5'd7, 1'b1, 32'hDEADBEEF, 2'd0);
    dead = 1'b0;

    // Stall with a valid response: everything freezes, then 1 and 2 are served in order
    set_addr(1, 5'd9);
    set_addr(2, 5'd10);
    bus.rd_stall = 1'b1;
    for (int i = 0; i < 3; i++)
      step($sformatf("stall%0d", i), 4'b0110, 4'b0000, 5'd7, 1'b1, 32'hDEADBEEF, 2'd0);
    bus.rd_stall = 1'b0;
    step("rel1", 4'b0110, 4'b0010, 5'd9,  1'b1, 32'h91, 2'd1);
    step("rel2", 4'b0110, 4'b0100, 5'd10, 1'b1, 32'hA1, 2'd2);

    // Pointer at 1: 3 goes before 1; then pointer at 3 wraps back to 1
    set_addr(3, 5'd12);
    step("ptr1",  4'b0010, 4'b0010, 5'd9,  1'b1, 32'h91, 2'd1);
    step("rr3",   4'b1010, 4'b1000, 5'd12, 1'b1, 32'hC1, 2'd3);
    step("wrap1", 4'b1010, 4'b0010, 5'd9,  1'b1, 32'h91, 2'd1);

    // Idle cycle drops valid; a stall with no valid response does not block
    step("idle", 4'b0000, 4'b0000, 5'd9, 1'b0, 32'h0, 2'd0);
    bus.rd_stall = 1'b1;
    step("nvstall", 4'b0100, 4'b0100, 5'd10, 1'b1, 32'hA1, 2'd2);
    bus.rd_stall = 1'b0;

    // Reset right after a grant discards the pending response and restarts the pointer
    set_addr(0, 5'd5);
    step("pre", 4'b0001, 4'b0001, 5'd5, 1'b1, 32'h51, 2'd0);
    @(negedge clock);
    reset = 1'b1;
    bus.req = 4'b1111;
    #1;
    check("midrst.grant",   32'(bus.grant),   32'h0);
    check("midrst.mux_sel", 32'(bus.mux_sel), 32'h0);
    @(posedge clock);
    #1;
    check("midrst.rd_valid", 32'(bus.rd_valid), 32'h0);
    check("midrst.rd_data",  bus.rd_data,       32'h0);
    @(negedge clock);
    reset = 1'b0;
    step("post3", 4'b1000, 4'b1000, 5'd12, 1'b1, 32'hC1, 2'd3);
    step("post0", 4'b1111, 4'b0001, 5'd5,  1'b1, 32'h51, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule
